// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
// master = execute-stage driver, slave = the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             inv_a;
  logic             inv_b;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             ofl;
  logic             zero;
  logic             neg;
  logic             dz;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, cin, inv_a, inv_b, sign, out_ready,
    input  in_ready, out_valid, out, out_hi, ofl, zero, neg, dz, illegal
  );

  modport slave (
    input  in_valid, op, a, b, cin, inv_a, inv_b, sign, out_ready,
    output in_ready, out_valid, out, out_hi, ofl, zero, neg, dz, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Ops 0-7 finish in one cycle; multiply and
// divide iterate one bit per cycle on operand magnitudes and fix the
// signs of the double-width result at the end.
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int SW    = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;      // partial product high / running remainder
  logic [WIDTH-1:0] lo_q, lo_d;      // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0] araw_q, araw_d;  // original dividend, returned on divide by zero
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             flip_lo_q, flip_lo_d;  // negate product / quotient
  logic             flip_hi_q, flip_hi_d;  // negate remainder
  logic             bzero_q, bzero_d;
  logic             minov_q, minov_d;      // signed MIN / -1
  logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic             ofl_q, ofl_d, zero_q, zero_d, neg_q, neg_d;
  logic             dz_q, dz_d, illegal_q, illegal_d;

  logic [WIDTH-1:0]   a_p, b_p, alu_res, mag_a, mag_b;
  logic [SW-1:0]      amt;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH:0]     sum;
  logic               alu_ofl;

  // Single-cycle ops on the (optionally inverted) request operands
  always_comb begin
    a_p     = bus.inv_a ? ~bus.a : bus.a;
    b_p     = bus.inv_b ? ~bus.b : bus.b;
    amt     = b_p[SW-1:0];
    rot     = {a_p, a_p} << amt;
    sum     = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, bus.cin};
    alu_res = '0;
    alu_ofl = 1'b0;
    case (bus.op[2:0])
      3'd0: alu_res = rot[2*WIDTH-1:WIDTH];
      3'd1: alu_res = a_p << amt;
      3'd2: alu_res = $signed(a_p) >>> amt;
      3'd3: alu_res = a_p >> amt;
      3'd4: begin
        alu_res = sum[WIDTH-1:0];
        // carry into the MSB is recovered from the MSB sum bit
        alu_ofl = bus.sign ? ((a_p[WIDTH-1] ^ b_p[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH])
                           : sum[WIDTH];
      end
      3'd5: alu_res = a_p | b_p;
      3'd6: alu_res = a_p ^ b_p;
      default: alu_res = a_p & b_p;
    endcase
    mag_a = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  logic [WIDTH:0]     msum, dshift, ddiff;
  logic [WIDTH-1:0]   it_hi, it_lo, quo, rem;
  logic [2*WIDTH-1:0] prod;

  // One multiply (shift-add) or divide (restoring) step plus sign fix-up
  always_comb begin
    msum   = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & m_q};
    dshift = {hi_q, lo_q[WIDTH-1]};
    ddiff  = dshift - {1'b0, m_q};
    if (state_q == MUL) begin
      it_hi = msum[WIDTH:1];
      it_lo = {msum[0], lo_q[WIDTH-1:1]};
    end else begin
      it_hi = ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], ~ddiff[WIDTH]};
    end
    prod = flip_lo_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    quo  = flip_lo_q ? -it_lo : it_lo;
    rem  = flip_hi_q ? -it_hi : it_hi;
  end

  logic             load;
  logic [WIDTH-1:0] res_out, res_hi;
  logic             res_ofl, res_dz, res_ill;

  // Next-state, operand capture and result load
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    araw_d    = araw_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    flip_lo_d = flip_lo_q;
    flip_hi_d = flip_hi_q;
    bzero_d   = bzero_q;
    minov_d   = minov_q;
    out_d     = out_q;
    out_hi_d  = out_hi_q;
    ofl_d     = ofl_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    dz_d      = dz_q;
    illegal_d = illegal_q;
    load      = 1'b0;
    res_out   = '0;
    res_hi    = '0;
    res_ofl   = 1'b0;
    res_dz    = 1'b0;
    res_ill   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          araw_d    = bus.a;
          sgn_d     = bus.sign;
          flip_lo_d = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          flip_hi_d = bus.sign & bus.a[WIDTH-1];
          bzero_d   = (bus.b == '0);
          minov_d   = bus.sign && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.b);
          hi_d      = '0;
          cnt_d     = '0;
          if (bus.op == 4'd8) begin
            state_d = MUL;
            m_d     = mag_a;
            lo_d    = mag_b;
          end else if (bus.op == 4'd9) begin
            state_d = DIV;
            m_d     = mag_b;
            lo_d    = mag_a;
          end else begin
            state_d = DONE;
            load    = 1'b1;
            res_out = bus.op[3] ? '0 : alu_res;
            res_ofl = ~bus.op[3] & alu_ofl;
            res_ill = bus.op[3];
          end
        end
      end
      MUL, DIV: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(WIDTH-1)) begin
          state_d = DONE;
          load    = 1'b1;
          if (state_q == MUL) begin
            res_out = prod[WIDTH-1:0];
            res_hi  = prod[2*WIDTH-1:WIDTH];
            res_ofl = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                            : (prod[2*WIDTH-1:WIDTH] != '0);
          end else if (bzero_q) begin
            res_out = '1;
            res_hi  = araw_q;
            res_dz  = 1'b1;
          end else begin
            res_out = quo;
            res_hi  = rem;
            res_ofl = minov_q;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      out_d     = res_out;
      out_hi_d  = res_hi;
      ofl_d     = res_ofl;
      dz_d      = res_dz;
      illegal_d = res_ill;
      zero_d    = (res_out == '0);
      neg_d     = res_out[WIDTH-1];
    end
  end

  // State and datapath registers; reset abandons any iteration in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      araw_q    <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      flip_lo_q <= 1'b0;
      flip_hi_q <= 1'b0;
      bzero_q   <= 1'b0;
      minov_q   <= 1'b0;
      out_q     <= '0;
      out_hi_q  <= '0;
      ofl_q     <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      araw_q    <= araw_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      flip_lo_q <= flip_lo_d;
      flip_hi_q <= flip_hi_d;
      bzero_q   <= bzero_d;
      minov_q   <= minov_d;
      out_q     <= out_d;
      out_hi_q  <= out_hi_d;
      ofl_q     <= ofl_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      dz_q      <= dz_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.out_hi    = out_hi_q;
  assign bus.ofl       = ofl_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.dz        = dz_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table, handshake/reset sequences and random
// transactions for 16- and 32-bit instances of alu_seq.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;   // 0 drives the 16-bit DUT, 1 the 32-bit DUT
  logic        req_valid = 1'b0, req_oready = 1'b0;
  logic [3:0]  op_v = '0;
  logic [63:0] a_v = '0, b_v = '0;
  logic        cin_v = 1'b0, ia_v = 1'b0, ib_v = 1'b0, sg_v = 1'b0;

  alu_seq_if #(.WIDTH(16)) b16 ();
  alu_seq_if #(.WIDTH(32)) b32 ();

  alu_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  alu_seq #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  assign b16.in_valid  = req_valid & ~sel;
  assign b16.out_ready = req_oready & ~sel;
  assign b16.op = op_v;  assign b16.a = a_v[15:0];  assign b16.b = b_v[15:0];
  assign b16.cin = cin_v; assign b16.inv_a = ia_v; assign b16.inv_b = ib_v; assign b16.sign = sg_v;
  assign b32.in_valid  = req_valid & sel;
  assign b32.out_ready = req_oready & sel;
  assign b32.op = op_v;  assign b32.a = a_v[31:0];  assign b32.b = b_v[31:0];
  assign b32.cin = cin_v; assign b32.inv_a = ia_v; assign b32.inv_b = ib_v; assign b32.sign = sg_v;

  logic        v_in_ready, v_out_valid, v_ofl, v_zero, v_neg, v_dz, v_ill;
  logic [63:0] v_out, v_hi;
  always_comb begin
    if (sel) begin
      v_in_ready = b32.in_ready; v_out_valid = b32.out_valid;
      v_out = {32'b0, b32.out};  v_hi = {32'b0, b32.out_hi};
      v_ofl = b32.ofl; v_zero = b32.zero; v_neg = b32.neg; v_dz = b32.dz; v_ill = b32.illegal;
    end else begin
      v_in_ready = b16.in_ready; v_out_valid = b16.out_valid;
      v_out = {48'b0, b16.out};  v_hi = {48'b0, b16.out_hi};
      v_ofl = b16.ofl; v_zero = b16.zero; v_neg = b16.neg; v_dz = b16.dz; v_ill = b16.illegal;
    end
  end

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [63:0] v, input int w);
    logic [63:0] t;
    t = v << (64 - w);
    return $signed(t) >>> (64 - w);
  endfunction

  // Reference model: plain integer arithmetic on the architectural rules
  task automatic model(input int w, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic ia, input logic ib, input logic sg,
                       output logic [63:0] eo, output logic [63:0] eh,
                       output logic eofl, output logic edz, output logic eill);
    logic [63:0]  m, ap, bp, s;
    longint       sa, sb, ss, smax, smin;
    logic [127:0] up;
    int           amt;
    m    = (64'd1 << w) - 64'd1;
    smax = (longint'(1) <<< (w - 1)) - 1;
    smin = -smax - 1;
    ap   = (ia ? ~a : a) & m;
    bp   = (ib ? ~b : b) & m;
    amt  = int'(bp & 64'(w - 1));
    eo = '0; eh = '0; eofl = 1'b0; edz = 1'b0; eill = 1'b0;
    case (op)
      4'd0: eo = ((ap << amt) | (ap >> (w - amt))) & m;
      4'd1: eo = (ap << amt) & m;
      4'd2: eo = 64'(sx(ap, w) >>> amt) & m;
      4'd3: eo = ap >> amt;
      4'd4: begin
        s  = ap + bp + 64'(cin);
        eo = s & m;
        if (sg) begin
          ss   = sx(ap, w) + sx(bp, w) + longint'(cin);
          eofl = (ss > smax) || (ss < smin);
        end else eofl = s[w];
      end
      4'd5: eo = ap | bp;
      4'd6: eo = ap ^ bp;
      4'd7: eo = ap & bp;
      4'd8: begin
        if (sg) begin
          ss   = sx(a, w) * sx(b, w);
          eo   = 64'(ss) & m;
          eh   = (64'(ss) >> w) & m;
          eofl = (ss > smax) || (ss < smin);
        end else begin
          up   = 128'(a) * 128'(b);
          eo   = up[63:0] & m;
          eh   = 64'(up >> w) & m;
          eofl = (up >> w) != 0;
        end
      end
      4'd9: begin
        if (b == 0) begin
          eo = m; eh = a; edz = 1'b1;
        end else if (sg && sx(a, w) == smin && sx(b, w) == -1) begin
          eo = 64'(smin) & m; eh = '0; eofl = 1'b1;
        end else if (sg) begin
          sa = sx(a, w); sb = sx(b, w);
          eo = 64'(sa / sb) & m;
          eh = 64'(sa % sb) & m;
        end else begin
          eo = a / b; eh = a % b;
        end
      end
      default: eill = 1'b1;
    endcase
  endtask

  // Issue one request, wait for the result, check it, then consume it
  task automatic run_txn(input string tag, input logic s, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic ia, input logic ib, input logic sg,
                         input logic [63:0] eo, input logic [63:0] eh,
                         input logic eofl, input logic edz, input logic eill);
    int w, t, lat, elat;
    w = s ? 32 : 16;
    elat = (op == 4'd8 || op == 4'd9) ? w + 1 : 1;
    @(negedge clk);
    sel = s; op_v = op; a_v = a; b_v = b;
    cin_v = cin; ia_v = ia; ib_v = ib; sg_v = sg;
    req_valid = 1'b1;
    #1;
    t = 0;
    while (!v_in_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (t >= 50) begin
      nerr++;
      $display("FAIL %s accept: in_ready never rose, required 1", tag);
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!v_out_valid && lat < 100) begin @(negedge clk); lat++; end
    $display("txn %s w=%0d op=%0d a=%h b=%h out=%h hi=%h ofl=%b dz=%b ill=%b lat=%0d",
             tag, w, op, a, b, v_out, v_hi, v_ofl, v_dz, v_ill, lat);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " out"}, v_out, eo);
    chk({tag, " out_hi"}, v_hi, eh);
    chk({tag, " ofl"}, 64'(v_ofl), 64'(eofl));
    chk({tag, " dz"}, 64'(v_dz), 64'(edz));
    chk({tag, " illegal"}, 64'(v_ill), 64'(eill));
    chk({tag, " zero"}, 64'(v_zero), 64'(eo == 64'd0));
    chk({tag, " neg"}, 64'(v_neg), 64'(eo[w-1]));
    req_oready = 1'b1;
    @(negedge clk);
    req_oready = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic        cin, ia, ib, sg;
    logic [63:0] eo, eh;
    logic        eofl, edz, eill;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic cin, input logic ia, input logic ib, input logic sg,
                              input logic [63:0] eo, input logic [63:0] eh,
                              input logic eofl, input logic edz, input logic eill);
    vec_t v;
    v.s = s; v.op = op; v.a = a; v.b = b; v.cin = cin; v.ia = ia; v.ib = ib; v.sg = sg;
    v.eo = eo; v.eh = eh; v.eofl = eofl; v.edz = edz; v.eill = eill;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    logic [63:0] eo, eh, ra, rb, msk;
    logic        eofl, edz, eill, rs;
    logic [3:0]  rop;
    int          lat, hits, w, r;

    // s op a b cin ia ib sg | out hi ofl dz ill
    tbl[0]  = mk(1'b0, 4'd4, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000, 64'h0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 4'd4, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 4'd0, 64'h8001, 64'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0018, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 4'd2, 64'h8000, 64'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 4'd7, 64'h00FF, 64'h000F, 1'b0, 1'b0, 1'b1, 1'b0, 64'h00F0, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 4'd8, 64'hFFFE, 64'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFA, 64'hFFFF, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 4'd8, 64'h0100, 64'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000, 64'h0001, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 4'd9, 64'hFFF9, 64'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFD, 64'hFFFF, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 4'd9, 64'h1234, 64'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF, 64'h1234, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 4'd9, 64'h8000, 64'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000, 64'h0000, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 4'd12, 64'h1234, 64'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000, 64'h0, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(1'b0, 4'd1, 64'h0001, 64'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 4'd3, 64'h8000, 64'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0001, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 4'd4, 64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h80000000, 64'h0, 1'b1, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 4'd4, 64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 4'd8, 64'hFFFFFFFE, 64'h3, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFA, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 4'd8, 64'h00010000, 64'h00010000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h1, 1'b1, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst in_ready16", 64'(b16.in_ready), 64'd1);
    chk("rst out_valid16", 64'(b16.out_valid), 64'd0);
    chk("rst out16", 64'(b16.out), 64'd0);
    chk("rst zero16", 64'(b16.zero), 64'd0);
    chk("rst in_ready32", 64'(b32.in_ready), 64'd1);
    chk("rst out32", 64'(b32.out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].s, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin,
              tbl[i].ia, tbl[i].ib, tbl[i].sg, tbl[i].eo, tbl[i].eh, tbl[i].eofl, tbl[i].edz, tbl[i].eill);

    // Busy rejection and output backpressure around a multiply (7*9)
    @(negedge clk);
    sel = 1'b0; op_v = 4'd8; a_v = 64'd7; b_v = 64'd9; cin_v = 1'b0; ia_v = 1'b0; ib_v = 1'b0; sg_v = 1'b0;
    req_valid = 1'b1;
    #1 chk("bp idle in_ready", 64'(v_in_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    op_v = 4'd4; a_v = 64'd1; b_v = 64'd2; req_valid = 1'b1;
    #1 chk("bp busy in_ready", 64'(v_in_ready), 64'd0);
    @(negedge clk);
    lat++;
    req_valid = 1'b0;
    while (!v_out_valid && lat < 100) begin @(negedge clk); lat++; end
    $display("txn bp_mul w=16 op=8 a=7 b=9 out=%h hi=%h lat=%0d", v_out, v_hi, lat);
    chk("bp mul latency", 64'(lat), 64'd17);
    chk("bp mul out", v_out, 64'd63);
    chk("bp mul out_hi", v_hi, 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d out", k), v_out, 64'd63);
      chk($sformatf("bp hold%0d in_ready", k), 64'(v_in_ready), 64'd0);
      chk($sformatf("bp hold%0d out_valid", k), 64'(v_out_valid), 64'd1);
    end
    op_v = 4'd4; a_v = 64'd5; b_v = 64'd6; req_valid = 1'b1; req_oready = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", 64'(v_in_ready), 64'd1);
    chk("bp release out_valid", 64'(v_out_valid), 64'd0);
    req_oready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    $display("txn bp_add w=16 op=4 a=5 b=6 out=%h valid=%b", v_out, v_out_valid);
    chk("bp next out_valid", 64'(v_out_valid), 64'd1);
    chk("bp next out", v_out, 64'd11);
    req_oready = 1'b1;
    @(negedge clk);
    req_oready = 1'b0;

    // Reset in the middle of a divide
    op_v = 4'd9; a_v = 64'd100; b_v = 64'd7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("txn rst_div w=16 out=%h hi=%h valid=%b ready=%b", b16.out, b16.out_hi, b16.out_valid, b16.in_ready);
    chk("rstdiv out", 64'(b16.out), 64'd0);
    chk("rstdiv out_hi", 64'(b16.out_hi), 64'd0);
    chk("rstdiv flags", 64'({b16.ofl, b16.zero, b16.neg, b16.dz, b16.illegal}), 64'd0);
    chk("rstdiv out_valid", 64'(b16.out_valid), 64'd0);
    chk("rstdiv in_ready", 64'(b16.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (25) begin @(negedge clk); if (b16.out_valid) hits++; end
    chk("rstdiv abandoned", 64'(hits), 64'd0);
    chk("rstdiv ready after", 64'(b16.in_ready), 64'd1);

    // Randomised transactions against the reference model
    for (int i = 0; i < 240; i++) begin
      rs  = (i >= 180);
      w   = rs ? 32 : 16;
      msk = (64'd1 << w) - 64'd1;
      r   = int'($urandom_range(0, 21));
      rop = (r < 16) ? 4'(r) : ((r < 19) ? 4'd8 : 4'd9);
      ra  = {$urandom, $urandom} & msk;
      rb  = {$urandom, $urandom} & msk;
      if ($urandom_range(0, 9) == 0) rb = 64'd0;
      if ($urandom_range(0, 9) == 0) ra = (64'd1 << (w - 1));
      if ($urandom_range(0, 9) == 0) rb = msk;
      if ($urandom_range(0, 3) == 0) rb = rb & 64'hF;
      cin_v = 1'($urandom); ia_v = 1'($urandom); ib_v = 1'($urandom); sg_v = 1'($urandom);
      model(w, rop, ra, rb, cin_v, ia_v, ib_v, sg_v, eo, eh, eofl, edz, eill);
      run_txn($sformatf("rnd%0d", i), rs, rop, ra, rb, cin_v, ia_v, ib_v, sg_v, eo, eh, eofl, edz, eill);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
